// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization for the FPU adder datapath.
// Takes the raw mantissa sum (with carry-out) and the common exponent.
// It right-shifts once on carry, or left-shifts one bit per cycle until the
// hidden bit is set. It adjusts the exponent and flags overflow, underflow
// and zero. One operand is in flight at a time.
module fp_normalizer #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_WIDTH:0]   man_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic                 sign_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_WIDTH-1:0] man_out,
  output logic [EXP_WIDTH-1:0] exp_out,
  output logic                 sign_out,
  output logic [4:0]           shift_count,
  output logic                 round_bit,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 zero
);

  localparam logic [EXP_WIDTH-1:0] EXP_MAX = {EXP_WIDTH{1'b1}};
  localparam logic [EXP_WIDTH-1:0] EXP_ONE = {{(EXP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [MAN_WIDTH:0]   man_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [EXP_WIDTH-1:0] exp_inc;
  logic                 hidden;
  logic                 carry;
  logic                 exp_is_max;
  logic                 man_is_zero;
  logic                 exp_floor;

  assign exp_inc     = exp_r + EXP_ONE;
  assign hidden      = man_r[MAN_WIDTH-1];
  assign carry       = man_r[MAN_WIDTH];
  assign exp_is_max  = (exp_r == EXP_MAX);
  assign man_is_zero = (man_r == '0);
  // An exponent of 1 (or 0) cannot go lower: the result becomes denormal.
  assign exp_floor   = (exp_r <= EXP_ONE);

  assign man_out = man_r[MAN_WIDTH-1:0];
  assign exp_out = exp_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = CHECK;
      CHECK: begin
        if (exp_is_max || man_is_zero || carry || hidden) state_nxt = DONE;
        else                                               state_nxt = SHIFT;
      end
      SHIFT: if (hidden || exp_floor) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Mantissa/exponent datapath and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      man_r       <= '0;
      exp_r       <= '0;
      sign_out    <= 1'b0;
      shift_count <= '0;
      round_bit   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          man_r       <= man_in;
          exp_r       <= exp_in;
          sign_out    <= sign_in;
          shift_count <= '0;
          round_bit   <= 1'b0;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          zero        <= 1'b0;
        end
        CHECK: begin
          if (exp_is_max) begin
            // inf/NaN: pass the mantissa field through, drop any carry
            man_r <= {1'b0, man_r[MAN_WIDTH-1:0]};
          end else if (man_is_zero) begin
            exp_r <= '0;
            zero  <= 1'b1;
          end else if (carry) begin
            round_bit <= man_r[0];
            exp_r     <= exp_inc;
            if (exp_inc == EXP_MAX) begin
              man_r    <= '0;
              overflow <= 1'b1;
            end else begin
              man_r <= {1'b0, man_r[MAN_WIDTH:1]};
            end
          end
        end
        SHIFT: if (!hidden) begin
          if (exp_floor) begin
            exp_r     <= '0;
            underflow <= 1'b1;
          end else begin
            man_r       <= man_r << 1;
            exp_r       <= exp_r - EXP_ONE;
            shift_count <= shift_count + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer with hand-computed expected values.
module tb_fp_normalizer;
  localparam int EW = 8;
  localparam int MW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [MW:0]   man_in;
  logic [EW-1:0] exp_in;
  logic          sign_in;
  logic          out_valid, out_ready;
  logic [MW-1:0] man_out;
  logic [EW-1:0] exp_out;
  logic          sign_out;
  logic [4:0]    shift_count;
  logic          round_bit, overflow, underflow, zero;

  int checks = 0;
  int failures = 0;
  int edges;

  always #5 clk = ~clk;

  fp_normalizer #(.EXP_WIDTH(EW), .MAN_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .man_in(man_in), .exp_in(exp_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .man_out(man_out), .exp_out(exp_out), .sign_out(sign_out),
    .shift_count(shift_count), .round_bit(round_bit),
    .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand, count edges from the accept edge until out_valid.
  task automatic launch(input logic [MW:0] m, input logic [EW-1:0] e, input logic s);
    man_in = m; exp_in = e; sign_in = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic check_res(input string tag, input logic [MW-1:0] m, input logic [EW-1:0] e,
                           input logic s, input logic [4:0] sc, input logic rb, input logic ov,
                           input logic uf, input logic z, input int lat);
    chk({tag, "_man"},   64'(man_out), 64'(m));
    chk({tag, "_exp"},   64'(exp_out), 64'(e));
    chk({tag, "_sign"},  64'(sign_out), 64'(s));
    chk({tag, "_shcnt"}, 64'(shift_count), 64'(sc));
    chk({tag, "_flags"}, 64'({round_bit, overflow, underflow, zero}), 64'({rb, ov, uf, z}));
    chk({tag, "_lat"},   64'(edges), 64'(lat));
    chk({tag, "_inrdy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_in_ready",  64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [MW-1:0] held_man;
    logic [EW-1:0] held_exp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    man_in = '0; exp_in = '0; sign_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", 64'({man_out, exp_out, sign_out, shift_count, round_bit, overflow, underflow, zero}), 64'd0);
    rst = 1'b0;

    // 1: already normalized
    launch(25'h0800000, 8'h80, 1'b1);
    check_res("norm", 24'h800000, 8'h80, 1'b1, 5'd0, 0, 0, 0, 0, 2);
    drain();

    // 2: carry-out right shift
    launch(25'h1800001, 8'h80, 1'b0);
    check_res("carry", 24'hC00000, 8'h81, 1'b0, 5'd0, 1, 0, 0, 0, 2);
    drain();

    // 3: left shift by 15
    launch(25'h0000100, 8'h90, 1'b0);
    check_res("lshift", 24'h800000, 8'h81, 1'b0, 5'd15, 0, 0, 0, 0, 18);
    drain();

    // 4: overflow then zero
    launch(25'h1000000, 8'hFE, 1'b1);
    check_res("ovf", 24'h000000, 8'hFF, 1'b1, 5'd0, 0, 1, 0, 0, 2);
    drain();
    launch(25'h0000000, 8'h40, 1'b0);
    check_res("zero", 24'h000000, 8'h00, 1'b0, 5'd0, 0, 0, 0, 1, 2);
    drain();

    // 5: underflow to denormal
    launch(25'h0000100, 8'h03, 1'b0);
    check_res("uflow", 24'h000400, 8'h00, 1'b0, 5'd2, 0, 0, 1, 0, 5);
    drain();

    // inf/NaN pass-through, carry bit dropped
    launch(25'h1123456, 8'hFF, 1'b1);
    check_res("inf", 24'h123456, 8'hFF, 1'b1, 5'd0, 0, 0, 0, 0, 2);

    // 6a: backpressure, with a new operand offered while DONE
    held_man = man_out; held_exp = exp_out;
    man_in = 25'h0800000; exp_in = 8'h10; sign_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stable", 64'({man_out, exp_out}), 64'({held_man, held_exp}));
    end
    in_valid = 1'b0;
    drain();

    // 6b: reset mid-SHIFT
    man_in = 25'h0000100; exp_in = 8'h90; sign_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_shift_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_shift_valid", 64'(out_valid), 64'd0);
    chk("rst_shift_ready", 64'(in_ready), 64'd1);
    chk("rst_shift_cnt", 64'(shift_count), 64'd0);

    // 6c: next operand after reset
    launch(25'h0000001, 8'h7F, 1'b0);
    check_res("post_rst", 24'h800000, 8'h68, 1'b0, 5'd23, 0, 0, 0, 0, 26);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
Post-add normalization stage for the FPU adder datapath, and the inverse of the exponent-alignment step. Alignment right-shifts the smaller operand by the exponent difference; this block takes the raw mantissa sum and the common (larger) exponent and shifts back to a normalized mantissa. It right-shifts once on carry-out, or left-shifts one bit per cycle until the hidden bit is set. The exponent is adjusted as it shifts, and overflow, underflow and zero are flagged. Valid/ready handshake on both sides.

Parameters:
EXP_WIDTH, 8, exponent field width
MAN_WIDTH, 24, mantissa width including hidden bit (max 32)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input operand valid
in_ready  out  1  block can accept operand
man_in  in  MAN_WIDTH+1  raw sum, bit MAN_WIDTH = carry-out
exp_in  in  EXP_WIDTH  common exponent from alignment stage
sign_in  in  1  result sign
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
man_out  out  MAN_WIDTH  normalized mantissa
exp_out  out  EXP_WIDTH  adjusted exponent
sign_out  out  1  sign, passed through
shift_count  out  5  number of left shifts performed
round_bit  out  1  bit discarded by carry right-shift
overflow  out  1  exponent reached all-ones
underflow  out  1  result denormal, exponent forced to 0
zero  out  1  mantissa sum was zero

Behaviour:
- States: IDLE, CHECK, SHIFT, DONE. Reset, or rst asserted in any state including mid-SHIFT:
  - state=IDLE
  - all outputs 0 except in_ready=1
  - operand discarded
- IDLE:
  - in_ready=1.
  - On in_valid, capture man_in, exp_in and sign_in; clear flags and shift_count; go to CHECK.
- CHECK (exactly one cycle), priority order:
  1. exp_in all-ones (inf/NaN): pass through. man_out = man_in[MAN_WIDTH-1:0], no flags. Go to DONE.
  2. man==0: man_out=0, exp_out=0, zero=1. Go to DONE.
  3. Carry bit set: man_out = man[MAN_WIDTH:1], round_bit = man[0], exp = exp+1. If the new exp is all-ones: overflow=1 and man_out=0 (infinity). Go to DONE.
  4. Bit MAN_WIDTH-1 set: already normalized. Go to DONE.
  5. Otherwise go to SHIFT.
- SHIFT (one step per cycle):
  - If bit MAN_WIDTH-1 is set: go to DONE.
  - Else if exp==1: exp=0, underflow=1, mantissa left unshifted (denormal). Go to DONE.
  - Else: man<<=1, exp-=1, shift_count+=1.
  - Maximum shift count is MAN_WIDTH-1.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE and drop out_valid the next cycle.
- in_ready=0 in all states except IDLE. No input is accepted while a result is pending: one operand in flight.
- Latency, counted from the accept edge:
  - out_valid is high after 2 edges when no left shift is needed.
  - With k left shifts, out_valid is high after k+3 edges.
- Exponent arithmetic is unsigned, EXP_WIDTH bits. The block never wraps below 0 or above all-ones.
- If in_valid is held during DONE, the operand is ignored until the block returns to IDLE.

Test Plan:
1. Normalized input (MAN_WIDTH=24): man_in=0x0800000, exp=0x80, sign=1.
   -> man_out=0x800000, exp_out=0x80, sign_out=1, shift_count=0, no flags, out_valid 2 edges after accept.
2. Carry-out: man_in=0x1800001, exp=0x80.
   -> man_out=0xC00000, exp_out=0x81, round_bit=1.
3. Left shift: man_in=0x0000100, exp=0x90.
   -> man_out=0x800000, exp_out=0x81, shift_count=15, out_valid 18 edges after accept.
4. Overflow, then zero:
   - man_in=0x1000000, exp=0xFE -> exp_out=0xFF, man_out=0, overflow=1.
   - man_in=0, exp=0x40 -> zero=1, exp_out=0.
5. Underflow: man_in=0x0000100, exp=0x03.
   -> shift_count=2, man_out=0x000400, exp_out=0x00, underflow=1.
6. Backpressure and reset:
   - out_ready low for 5 cycles -> outputs stable, in_ready=0.
   - rst asserted during SHIFT -> next cycle IDLE, out_valid=0, in_ready=1.
   - The next operand is processed correctly.
